if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL provide the ports listed in REQ-002 to REQ-011, all synchronous to clk; there SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-005 br_bus  input  34  {br_valid[33], br_taken[32], br_target[31:0]}; br_valid = decode ready_go; br_taken is already qualified by decode valid.
REQ-006 fs_to_ds_valid  output  1  fetch holds a valid instruction for decode.
REQ-007 fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.
REQ-008 inst_sram_en  output  1  instruction SRAM read enable.
REQ-009 inst_sram_wen  output  4  byte write enables; constant 4'h0.
REQ-010 inst_sram_addr / inst_sram_wdata  output  32 each  read address = nextpc; wdata constant 32'h0.
REQ-011 inst_sram_rdata  input  32  read data, valid exactly one cycle after an enabled request.

Function
REQ-012 The pre-IF logic SHALL compute seq_pc = fs_pc + 4, with 32-bit wrap-around and no carry out.
REQ-013 nextpc SHALL be selected by the following priority: br_buf_target if br_buf_valid; otherwise br_target if br_valid && br_taken; otherwise seq_pc.
REQ-014 to_fs_valid SHALL equal !reset && br_valid, so no fetch request issues while decode is not ready_go.
REQ-015 fs_ready_go SHALL be 1.
REQ-016 fs_allowin SHALL equal !fs_valid || (fs_ready_go && ds_allowin).
REQ-017 fs_to_ds_valid SHALL equal fs_valid && fs_ready_go.
REQ-018 inst_sram_en SHALL equal to_fs_valid && fs_allowin.
REQ-019 inst_sram_addr SHALL equal nextpc in every cycle.
REQ-020 When fs_allowin is 1, fs_valid SHALL load to_fs_valid.
REQ-021 When fs_allowin && to_fs_valid, fs_pc SHALL load nextpc.
REQ-022 fs_pc and fs_valid SHALL hold otherwise.
REQ-023 Instruction buffer: when fs_valid && !ds_allowin && !inst_buf_valid, the block SHALL capture inst_sram_rdata into inst_buf and set inst_buf_valid.
REQ-024 inst_buf_valid SHALL clear on the cycle fs_to_ds_valid && ds_allowin.
REQ-025 fs_inst SHALL equal inst_buf_valid ? inst_buf : inst_sram_rdata, so a stalled instruction is never lost when SRAM output changes.
REQ-026 Branch buffer: when br_valid && br_taken && !inst_sram_en, the block SHALL latch br_target into br_buf_target and set br_buf_valid.
REQ-027 br_buf_valid SHALL clear on the first cycle inst_sram_en = 1.
REQ-028 If a new taken branch arrives while br_buf_valid is 1, the block SHALL overwrite br_buf_target.
REQ-029 Delay slot: the instruction in fetch while decode holds a branch SHALL always be passed to decode; the branch redirects only the following request.
REQ-030 Simultaneous events: buffer set and clear in the same cycle SHALL resolve to clear for inst_buf (transfer wins) and to consume for br_buf (the request uses the target; no stale retention).
REQ-031 The block SHALL contain no combinational path from inst_sram_rdata to inst_sram_addr.

Reset
REQ-032 On reset, the block SHALL set fs_valid=0, fs_pc=32'hbfbffffc, inst_buf_valid=0, inst_buf=0, br_buf_valid=0 and br_buf_target=0.
REQ-033 During reset, inst_sram_en SHALL be 0 and fs_to_ds_valid SHALL be 0.
REQ-034 In the first cycle after reset deasserts with br_valid=1, inst_sram_en=1 and inst_sram_addr=32'hbfc00000.
REQ-035 Reset asserted mid-stall SHALL discard buffered instruction and branch state with no output in the following cycle.

Verification
REQ-036 Reset release, ds_allowin=1, br_bus={1,0,x} -> addresses bfc00000, bfc00004, bfc00008 on consecutive cycles; fs_to_ds_bus pc lags the address by one cycle.
REQ-037 Taken branch at fs_pc=bfc00010, br_target=bfc00100 -> next address bfc00100; the delay slot (pc bfc00010) is delivered to decode.
REQ-038 ds_allowin=0 for 3 cycles with fs_pc=bfc00008, while rdata changes to 0xdeadbeef after the first stall cycle -> fs_inst holds the original word and inst_sram_en=0 during the stall; on release the original word transfers and inst_buf_valid clears.
REQ-039 Taken branch (target bfc00200) while fs_allowin=0 for 2 cycles -> br_buf_valid=1; on release the address is bfc00200 and br_buf_valid clears the same cycle.
REQ-040 br_valid=0 for 2 cycles -> inst_sram_en=0 and fs_pc unchanged; resume at seq_pc.
REQ-041 fs_pc=32'hfffffffc sequential -> next address 32'h00000000 (wrap).

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a stall-safe instruction buffer and a
// branch-target buffer for redirects that arrive while no request can issue.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);
  localparam logic [31:0] RESET_PC = 32'hbfbffffc;
  logic        br_valid, br_taken, br_take;
  logic [31:0] br_target;
  logic [31:0] seq_pc, nextpc, fs_inst;
  logic        to_fs_valid, fs_ready_go, fs_allowin, inst_cap;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_buf_valid_q, br_buf_valid_d;
  logic [31:0] br_buf_target_q, br_buf_target_d;
  always_comb begin
    br_valid         = br_bus[33];
    br_taken         = br_bus[32];
    br_target        = br_bus[31:0];
    br_take          = br_valid && br_taken;
    seq_pc           = fs_pc_q + 32'd4;
    nextpc           = br_buf_valid_q ? br_buf_target_q : br_take ? br_target : seq_pc;
    to_fs_valid      = !reset && br_valid;
    fs_ready_go      = 1'b1;
    fs_allowin       = !fs_valid_q || (fs_ready_go && ds_allowin);
    fs_to_ds_valid   = fs_valid_q && fs_ready_go;
    inst_sram_en     = to_fs_valid && fs_allowin;
    inst_sram_wen    = 4'h0;
    inst_sram_addr   = nextpc;
    inst_sram_wdata  = 32'h0;
    fs_inst          = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    fs_to_ds_bus     = {fs_inst, fs_pc_q};
    fs_valid_d       = fs_allowin ? to_fs_valid : fs_valid_q;
    fs_pc_d          = (fs_allowin && to_fs_valid) ? nextpc : fs_pc_q;
    // SRAM data is only valid the cycle after a request, so hold it while decode stalls
    inst_cap         = fs_valid_q && !ds_allowin && !inst_buf_valid_q;
    inst_buf_valid_d = (fs_to_ds_valid && ds_allowin) ? 1'b0 : inst_cap ? 1'b1 : inst_buf_valid_q;
    inst_buf_d       = inst_cap ? inst_sram_rdata : inst_buf_q;
    br_buf_valid_d   = inst_sram_en ? 1'b0 : br_take ? 1'b1 : br_buf_valid_q;
    br_buf_target_d  = (br_take && !inst_sram_en) ? br_target : br_buf_target_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
      br_buf_valid_q   <= 1'b0;
      br_buf_target_q  <= 32'h0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_buf_valid_q   <= br_buf_valid_d;
      br_buf_target_q  <= br_buf_target_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random checks of if_stage against a fetch model
// where every delivered instruction must be the memory word at its own pc.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b1;
  logic [33:0] br_bus = 34'h0;
  logic        fs_to_ds_valid, inst_sram_en;
  logic [63:0] fs_to_ds_bus;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  int          n_pass = 0, n_total = 0;
  logic        chk_en = 1'b0;
  logic        m_valid = 1'b0, m_pend_v = 1'b0;
  logic [31:0] m_pc = 32'h0, m_pend_t = 32'h0;
  logic        s_en = 1'b0;
  logic [31:0] s_addr = 32'h0;

  if_stage dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic m_en();
    return !reset && br_bus[33] && (!m_valid || ds_allowin);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_pend_v ? m_pend_t : (br_bus[33] && br_bus[32]) ? br_bus[31:0] : m_pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // SRAM: word appears the cycle after an enabled read; otherwise the output is garbage
  always @(negedge clk) begin
    s_en   <= inst_sram_en;
    s_addr <= inst_sram_addr;
  end
  always @(posedge clk) inst_sram_rdata <= s_en ? mem(s_addr) : 32'hdeadbeef;

  always @(posedge clk) begin
    logic en;
    logic [31:0] a;
    en = m_en();
    a  = m_addr();
    if (reset) begin
      m_valid = 1'b0; m_pc = 32'hbfbffffc; m_pend_v = 1'b0; m_pend_t = 32'h0;
    end else begin
      if (!m_valid || ds_allowin) m_valid = br_bus[33];
      if (en) m_pc = a;
      if (en) m_pend_v = 1'b0;
      else if (br_bus[33] && br_bus[32]) begin m_pend_v = 1'b1; m_pend_t = br_bus[31:0]; end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("sram_en", 64'(inst_sram_en), 64'(m_en()));
    check("sram_addr", 64'(inst_sram_addr), 64'(m_addr()));
    check("fs_to_ds_valid", 64'(fs_to_ds_valid), 64'(m_valid));
    check("fs_pc", 64'(fs_to_ds_bus[31:0]), 64'(m_pc));
    if (m_valid) check("fs_inst", 64'(fs_to_ds_bus[63:32]), 64'(mem(m_pc)));
    check("wen_wdata", {28'h0, inst_sram_wen, inst_sram_wdata}, 64'h0);
  end

  task automatic step(input logic r, input logic ds, input logic bv, input logic bt, input logic [31:0] tg);
    @(posedge clk);
    #1;
    reset = r; ds_allowin = ds; br_bus = {bv, bt, tg};
    @(negedge clk);
    #1;
  endtask

  initial begin
    step(1, 1, 0, 0, 0);
    chk_en = 1'b1;
    step(1, 1, 1, 0, 0);
    check("lit_reset_en", 64'(inst_sram_en), 64'h0);
    check("lit_reset_valid", 64'(fs_to_ds_valid), 64'h0);
    step(0, 1, 1, 0, 0);
    check("lit_first_addr", 64'(inst_sram_addr), 64'hbfc00000);
    check("lit_first_en", 64'(inst_sram_en), 64'h1);
    step(0, 1, 1, 0, 0);
    check("lit_addr2", 64'(inst_sram_addr), 64'hbfc00004);
    check("lit_pc_lag", 64'(fs_to_ds_bus[31:0]), 64'hbfc00000);
    step(0, 1, 1, 0, 0);
    check("lit_addr3", 64'(inst_sram_addr), 64'hbfc00008);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'hbfc00100);
    check("lit_delay_slot_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00010);
    check("lit_branch_addr", 64'(inst_sram_addr), 64'hbfc00100);
    step(0, 1, 1, 0, 0);
    check("lit_branch_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00100);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      check("lit_stall_en", 64'(inst_sram_en), 64'h0);
      check("lit_stall_inst", 64'(fs_to_ds_bus[63:32]), 64'(mem(32'hbfc00104)));
    end
    step(0, 1, 1, 0, 0);
    check("lit_release_inst", 64'(fs_to_ds_bus[63:32]), 64'(mem(32'hbfc00104)));
    check("lit_release_addr", 64'(inst_sram_addr), 64'hbfc00108);
    step(0, 0, 1, 1, 32'hbfc00200);
    step(0, 0, 1, 0, 0);
    check("lit_brbuf_en", 64'(inst_sram_en), 64'h0);
    step(0, 1, 1, 0, 0);
    check("lit_brbuf_addr", 64'(inst_sram_addr), 64'hbfc00200);
    step(0, 1, 1, 0, 0);
    check("lit_brbuf_clear", 64'(inst_sram_addr), 64'hbfc00204);
    step(0, 1, 0, 0, 0);
    check("lit_nobr_en", 64'(inst_sram_en), 64'h0);
    step(0, 1, 0, 0, 0);
    check("lit_nobr_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00204);
    step(0, 1, 1, 0, 0);
    check("lit_resume", 64'(inst_sram_addr), 64'hbfc00208);
    step(0, 1, 1, 1, 32'hfffffffc);
    step(0, 1, 1, 0, 0);
    check("lit_wrap", 64'(inst_sram_addr), 64'h0);
    step(0, 0, 1, 1, 32'h12345678);
    step(1, 0, 1, 0, 0);
    check("lit_midstall_en", 64'(inst_sram_en), 64'h0);
    step(0, 1, 1, 0, 0);
    check("lit_midstall_valid", 64'(fs_to_ds_valid), 64'h0);
    check("lit_midstall_addr", 64'(inst_sram_addr), 64'hbfc00000);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(9) < 7, $urandom_range(9) < 8,
           $urandom_range(4) == 0, {$urandom_range(32'h3fffffff), 2'b00});
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
